// File: rtl/mrc_seq_core.sv
// Sequential signed multiply / integer square root / signed divide core, operands loaded one word per load press.
// Buttons are synchronised and edge-detected internally; one arithmetic iteration per clock while busy.
module mrc_seq_core #(
  parameter int WORD_LENGTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_n,
  input  logic                     load_n,
  input  logic [WORD_LENGTH-1:0]   Data,
  input  logic [1:0]               op,
  output logic                     x,
  output logic                     y,
  output logic                     busy,
  output logic                     ready,
  output logic                     error,
  output logic [2*WORD_LENGTH-1:0] Result
);
  localparam int WL = WORD_LENGTH;
  localparam int HW = WORD_LENGTH / 2;
  localparam int CW = $clog2(WORD_LENGTH);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_SQRT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, CALC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d, load_sync_q, load_sync_d;
  logic                   start_prev_q, start_prev_d, load_prev_q, load_prev_d;
  logic [1:0]             op_q, op_d;
  logic [WL-1:0]          xop_q, xop_d, yop_q, yop_d, aux_q, aux_d;
  logic [2*WL-1:0]        acc_q, acc_d, res_q, res_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   x_q, x_d, y_q, y_d, busy_q, busy_d, ready_q, ready_d, error_q, error_d;

  logic            start_p, load_p, start_acc, ld_x, ld_y, enter_calc, last_iter, precheck_err;
  logic [CW-1:0]   last_cnt;
  logic [WL-1:0]   opx, magx, magy, sq_sh, sq_q4, sq_rn, quo_f, rem_f;
  logic [WL:0]     mul_sum, div_sh, div_diff;
  logic [2*WL-1:0] acc_n, prod_f;

  function automatic logic [WL-1:0] neg_w(input logic [WL-1:0] v);
    return ~v + {{(WL-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WL-1:0] mag_w(input logic [WL-1:0] v);
    return v[WL-1] ? neg_w(v) : v;
  endfunction

  function automatic logic [2*WL-1:0] neg_2w(input logic [2*WL-1:0] v);
    return ~v + {{(2*WL-1){1'b0}}, 1'b1};
  endfunction

  // Falling edge of the synchronised (active-low) button gives a one-cycle pulse.
  always_comb begin
    start_sync_d = {start_sync_q[SYNC_STAGES-2:0], start_n};
    load_sync_d  = {load_sync_q[SYNC_STAGES-2:0], load_n};
    start_prev_d = start_sync_q[SYNC_STAGES-1];
    load_prev_d  = load_sync_q[SYNC_STAGES-1];
    start_p      = start_prev_q & ~start_sync_q[SYNC_STAGES-1];
    load_p       = load_prev_q & ~load_sync_q[SYNC_STAGES-1];
  end

  assign start_acc    = start_p && (state_q == IDLE || state_q == DONE);
  assign ld_x         = load_p && (state_q == LOAD_X);
  assign ld_y         = load_p && (state_q == LOAD_Y);
  assign enter_calc   = (ld_x && op_q == OP_SQRT) || ld_y;
  assign last_cnt     = (op_q == OP_SQRT) ? CW'(HW - 1) : CW'(WL - 1);
  assign last_iter    = (state_q == CALC) && (cnt_q == last_cnt);
  assign precheck_err = (state_q == CALC) && (cnt_q == '0) &&
                        ((op_q == OP_DIV && yop_q == '0) || (op_q == OP_SQRT && xop_q[WL-1]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      start_sync_q <= '0;
      load_sync_q  <= '0;
      start_prev_q <= 1'b0;
      load_prev_q  <= 1'b0;
      op_q         <= '0;
      xop_q        <= '0;
      yop_q        <= '0;
      aux_q        <= '0;
      acc_q        <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      x_q          <= 1'b0;
      y_q          <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_sync_q <= start_sync_d;
      load_sync_q  <= load_sync_d;
      start_prev_q <= start_prev_d;
      load_prev_q  <= load_prev_d;
      op_q         <= op_d;
      xop_q        <= xop_d;
      yop_q        <= yop_d;
      aux_q        <= aux_d;
      acc_q        <= acc_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_p) state_d = LOAD_X;
      LOAD_X: begin
        if (load_p) begin
          if (op_q == OP_SQRT)     state_d = CALC;
          else if (op_q == OP_RSV) state_d = DONE;
          else                     state_d = LOAD_Y;
        end
      end
      LOAD_Y:  if (load_p) state_d = CALC;
      CALC:    if (precheck_err || last_iter) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d     = (state_d == LOAD_X);
    y_d     = (state_d == LOAD_Y);
    busy_d  = (state_d == CALC);
    ready_d = ready_q;
    error_d = error_q;
    if (start_acc) begin
      ready_d = 1'b0;
      error_d = 1'b0;
    end else if ((ld_x && op_q == OP_RSV) || precheck_err) begin
      error_d = 1'b1;
    end else if (last_iter) begin
      ready_d = 1'b1;
    end
  end

  always_comb begin
    op_d  = start_acc ? op : op_q;
    xop_d = ld_x ? Data : xop_q;
    yop_d = ld_y ? Data : yop_q;
    opx   = ld_x ? Data : xop_q;
    magx  = mag_w(opx);
    magy  = mag_w(Data);

    mul_sum  = {1'b0, acc_q[2*WL-1:WL]} + (acc_q[0] ? {1'b0, aux_q} : '0);
    div_sh   = {acc_q[2*WL-1:WL], acc_q[WL-1]};
    div_diff = div_sh - {1'b0, aux_q};
    // Non-restoring sqrt: R in acc upper half, Q in acc low bits, radicand pairs shift out of aux.
    sq_sh    = {acc_q[2*WL-3:WL], aux_q[WL-1:WL-2]};
    sq_q4    = {{(WL-HW){1'b0}}, acc_q[HW-1:0]} << 2;
    sq_rn    = acc_q[2*WL-1] ? (sq_sh + (sq_q4 | {{(WL-2){1'b0}}, 2'b11}))
                             : (sq_sh - (sq_q4 | {{(WL-2){1'b0}}, 2'b01}));

    acc_n = acc_q;
    case (op_q)
      OP_MUL:  acc_n = {mul_sum, acc_q[WL-1:1]};
      OP_DIV:  acc_n = div_diff[WL] ? {div_sh[WL-1:0], acc_q[WL-2:0], 1'b0}
                                    : {div_diff[WL-1:0], acc_q[WL-2:0], 1'b1};
      OP_SQRT: acc_n = {sq_rn, {(WL-HW){1'b0}}, acc_q[HW-2:0], ~sq_rn[WL-1]};
      default: acc_n = acc_q;
    endcase

    quo_f  = (xop_q[WL-1] ^ yop_q[WL-1]) ? neg_w(acc_n[WL-1:0]) : acc_n[WL-1:0];
    rem_f  = xop_q[WL-1] ? neg_w(acc_n[2*WL-1:WL]) : acc_n[2*WL-1:WL];
    prod_f = (xop_q[WL-1] ^ yop_q[WL-1]) ? neg_2w(acc_n) : acc_n;

    acc_d = acc_q;
    aux_d = aux_q;
    cnt_d = '0;
    res_d = start_acc ? '0 : res_q;
    if (enter_calc) begin
      case (op_q)
        OP_MUL: begin
          acc_d = {{WL{1'b0}}, magy};
          aux_d = magx;
        end
        OP_DIV: begin
          acc_d = {{WL{1'b0}}, magx};
          aux_d = magy;
        end
        default: begin
          acc_d = '0;
          aux_d = opx;
        end
      endcase
    end else if (state_q == CALC) begin
      acc_d = acc_n;
      aux_d = (op_q == OP_SQRT) ? {aux_q[WL-3:0], 2'b00} : aux_q;
      cnt_d = cnt_q + CW'(1);
      if (last_iter && !precheck_err) begin
        case (op_q)
          OP_MUL:  res_d = prod_f;
          OP_DIV:  res_d = {rem_f, quo_f};
          default: res_d = {{(2*WL-HW){1'b0}}, acc_n[HW-1:0]};
        endcase
      end
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign busy   = busy_q;
  assign ready  = ready_q;
  assign error  = error_q;
  assign Result = res_q;

endmodule

// File: tb/tb_mrc_seq_core.sv
// Bench for mrc_seq_core: scoreboard of reference results, one task per scenario.
module tb_mrc_seq_core;
  localparam int WL = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start_n = 1'b1;
  logic            load_n = 1'b1;
  logic [WL-1:0]   Data = '0;
  logic [1:0]      op_i = 2'b00;
  logic            x, y, busy, ready, error;
  logic [2*WL-1:0] Result;

  typedef struct {
    logic [31:0] res;
    logic        rdy;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   busy_run = 0;
  int   excl_viol = 0;
  bit   y_seen = 1'b0;

  mrc_seq_core #(.WORD_LENGTH(WL), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .start_n(start_n), .load_n(load_n), .Data(Data), .op(op_i),
    .x(x), .y(y), .busy(busy), .ready(ready), .error(error), .Result(Result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (x) begin
      busy_run = 0;
      y_seen   = 1'b0;
    end else if (busy) begin
      busy_run++;
    end
    if (y) y_seen = 1'b1;
    if ($countones({x, y, busy, ready, error}) > 1) excl_viol++;
  end

  function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ai, bi, q, r;
    logic [31:0] qv, rv;
    ai = int'($signed(a));
    bi = int'($signed(b));
    e.res = '0; e.rdy = 1'b0; e.err = 1'b1; e.cyc = 1;
    case (o)
      2'd0: begin
        e.res = 32'(ai * bi); e.rdy = 1'b1; e.err = 1'b0; e.cyc = 16;
      end
      2'd1: if (ai >= 0) begin
        r = 0;
        while ((r + 1) * (r + 1) <= ai) r++;
        e.res = 32'(r); e.rdy = 1'b1; e.err = 1'b0; e.cyc = 8;
      end
      2'd2: if (bi != 0) begin
        q = ai / bi; r = ai % bi; qv = 32'(q); rv = 32'(r);
        e.res = {rv[15:0], qv[15:0]}; e.rdy = 1'b1; e.err = 1'b0; e.cyc = 16;
      end
      default: e.cyc = 0;
    endcase
    return e;
  endfunction

  task automatic press_start(input int hold);
    @(negedge clk); start_n = 1'b0;
    repeat (hold) @(negedge clk);
    start_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_load(input int hold);
    @(negedge clk); load_n = 1'b0;
    repeat (hold) @(negedge clk);
    load_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Full operation; optional long hold on the first load and a start press while busy.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input int hold_x, input bit poke_start, input string nm);
    exp_t e;
    bit done;
    sb_q.push_back(model(o, a, b));
    op_i = o;
    press_start(1);
    op_i = ~o;
    n_cmp++;
    if ({x, y, busy, ready, error} !== 5'b10000 || Result !== '0) begin
      n_fail++;
      $display("FAIL %s_start: flags=%b result=%h, expected flags=10000 result=0", nm, {x, y, busy, ready, error}, Result);
    end
    Data = a;
    press_load(hold_x);
    if (o == 2'd0 || o == 2'd2) begin
      n_cmp++;
      if ({x, y, busy} !== 3'b010) begin
        n_fail++;
        $display("FAIL %s_wait_y: x,y,busy=%b expected 010", nm, {x, y, busy});
      end
      Data = b;
      press_load(1);
    end
    if (poke_start) begin
      press_start(1);
      n_cmp++;
      if ({x, busy} !== 2'b01) begin
        n_fail++;
        $display("FAIL %s_start_in_calc: x,busy=%b expected 01", nm, {x, busy});
      end
    end
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ready || error) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: done=%0d expected 1", nm, done);
    end
    n_cmp++;
    if ({Result, ready, error} !== {e.res, e.rdy, e.err}) begin
      n_fail++;
      $display("FAIL %s_result: result=%h ready=%b error=%b, expected result=%h ready=%b error=%b",
               nm, Result, ready, error, e.res, e.rdy, e.err);
    end
    n_cmp++;
    if (busy_run != e.cyc) begin
      n_fail++;
      $display("FAIL %s_cycles: busy cycles=%0d expected %0d", nm, busy_run, e.cyc);
    end
    if (o == 2'd1) begin
      n_cmp++;
      if (y_seen) begin
        n_fail++;
        $display("FAIL %s_no_y: y_seen=%b expected 0", nm, y_seen);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({Result, ready, error} !== {e.res, e.rdy, e.err}) begin
      n_fail++;
      $display("FAIL %s_hold: result=%h ready=%b error=%b, expected result=%h ready=%b error=%b",
               nm, Result, ready, error, e.res, e.rdy, e.err);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({x, y, busy, ready, error, Result} !== '0) begin
      n_fail++;
      $display("FAIL reset_active: flags=%b result=%h expected all 0", {x, y, busy, ready, error}, Result);
    end
    reset = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({x, y, busy, ready, error, Result} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: flags=%b result=%h expected all 0", {x, y, busy, ready, error}, Result);
    end
  endtask

  task automatic test_multiply;
    logic [15:0] a, b;
    do_op(2'd0, 16'd7, 16'hFFFD, 1, 1'b0, "mul_7_m3");
    do_op(2'd0, 16'h8000, 16'h8000, 1, 1'b0, "mul_min_min");
    do_op(2'd0, 16'h8000, 16'd1, 1, 1'b0, "mul_min_1");
    do_op(2'd0, 16'h7FFF, 16'hFFFF, 1, 1'b0, "mul_max_m1");
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      do_op(2'd0, a, b, 1, 1'b0, "mul_rand");
    end
  endtask

  task automatic test_sqrt;
    logic [15:0] a;
    do_op(2'd1, 16'd144, 16'd0, 1, 1'b0, "sqrt_144");
    do_op(2'd1, 16'd32767, 16'd0, 1, 1'b0, "sqrt_32767");
    do_op(2'd1, 16'd0, 16'd0, 1, 1'b0, "sqrt_0");
    do_op(2'd1, 16'd15, 16'd0, 1, 1'b0, "sqrt_15");
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom_range(0, 32767));
      do_op(2'd1, a, 16'd0, 1, 1'b0, "sqrt_rand");
    end
  endtask

  task automatic test_divide;
    logic [15:0] a, b;
    do_op(2'd2, 16'd100, 16'd7, 1, 1'b0, "div_100_7");
    do_op(2'd2, 16'hFF9C, 16'd7, 1, 1'b0, "div_m100_7");
    do_op(2'd2, 16'd100, 16'hFFF9, 1, 1'b0, "div_100_m7");
    do_op(2'd2, 16'h8000, 16'hFFFF, 1, 1'b0, "div_overflow");
    do_op(2'd2, 16'd5, 16'd9, 1, 1'b0, "div_small");
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (b == '0) b = 16'd3;
      do_op(2'd2, a, b, 1, 1'b0, "div_rand");
    end
  endtask

  task automatic test_errors;
    do_op(2'd2, 16'd50, 16'd0, 1, 1'b0, "err_div0");
    do_op(2'd1, 16'hFFFC, 16'd0, 1, 1'b0, "err_sqrt_neg");
    do_op(2'd3, 16'd12, 16'd0, 1, 1'b0, "err_op3");
    do_op(2'd0, 16'd3, 16'd4, 1, 1'b0, "err_cleared");
  endtask

  task automatic test_handshake;
    do_op(2'd0, 16'd5, 16'd6, 50, 1'b0, "hold_load");
    do_op(2'd0, 16'd1000, 16'hFF00, 1, 1'b1, "start_in_calc");
    op_i = 2'd0;
    Data = 16'd9;
    @(negedge clk); start_n = 1'b0; load_n = 1'b0;
    @(negedge clk); start_n = 1'b1; load_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({x, y, busy, ready, error} !== 5'b10000) begin
      n_fail++;
      $display("FAIL start_load_same: flags=%b expected 10000", {x, y, busy, ready, error});
    end
    do_op(2'd0, 16'd11, 16'd3, 1, 1'b0, "after_same_cycle");
  endtask

  task automatic test_reset_mid_calc;
    op_i = 2'd0;
    press_start(1);
    Data = 16'd1234; press_load(1);
    Data = 16'd55;   press_load(1);
    for (int i = 0; i < 40 && busy_run < 5; i++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || busy_run != 5) begin
      n_fail++;
      $display("FAIL mid_calc_reach: busy=%b cycles=%0d expected busy=1 cycles=5", busy, busy_run);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({x, y, busy, ready, error, Result} !== '0) begin
      n_fail++;
      $display("FAIL mid_calc_async_reset: flags=%b result=%h expected all 0", {x, y, busy, ready, error}, Result);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({x, y, busy, ready, error, Result} !== '0) begin
      n_fail++;
      $display("FAIL mid_calc_idle: flags=%b result=%h expected all 0", {x, y, busy, ready, error}, Result);
    end
    do_op(2'd0, 16'd1234, 16'd55, 1, 1'b0, "mul_after_reset");
  endtask

  task automatic test_exclusive;
    n_cmp++;
    if (excl_viol != 0) begin
      n_fail++;
      $display("FAIL flag_exclusive: violations=%0d expected 0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_sqrt();
    test_divide();
    test_errors();
    test_handshake();
    test_reset_mid_calc();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
